// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter - shares one single-ported memory between instruction fetch and data access
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   halt                       blocks new fetch grants
//   if_req/if_addr             fetch request (level) and address
//   if_valid/if_rdata          one-cycle fetch completion pulse and registered instruction
//   dm_req/dm_we/dm_addr/dm_wdata  data request (level), store flag, address, store data
//   dm_valid/dm_rdata          one-cycle data completion pulse and registered load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory side, one strobe per transaction
//   stall_if/stall_mem         requester waiting for its completion pulse
//   busy                       a transaction is in flight
module mem_port_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 9,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    localparam int LAT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state;
    logic             owner_dm;
    logic             we_q;
    logic [LAT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve_cnt;

    logic if_want;
    logic starve_hit;
    logic grant_dm;
    logic grant_if;

    // Data wins unless fetch has already been passed over STARVE_MAX times in a row.
    assign if_want    = if_req && !halt;
    assign starve_hit = (starve_cnt == STV_W'(STARVE_MAX));
    assign grant_dm   = dm_req && !(if_want && starve_hit);
    assign grant_if   = !grant_dm && if_want;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            owner_dm   <= 1'b0;
            we_q       <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_dm) begin
                        owner_dm  <= 1'b1;
                        we_q      <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        state     <= S_ACCESS;
                        // A DM grant with fetch waiting implies the cap was not hit,
                        // so the increment cannot overflow.
                        if (if_want) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            starve_cnt <= '0;
                        end
                    end else if (grant_if) begin
                        owner_dm   <= 1'b0;
                        we_q       <= 1'b0;
                        mem_addr   <= if_addr;
                        state      <= S_ACCESS;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                S_ACCESS: begin
                    lat_cnt <= LAT_W'(1);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == LAT_W'(MEM_LAT)) begin
                        if (!owner_dm) begin
                            if_rdata <= mem_rdata;
                        end else if (!we_q) begin
                            dm_rdata <= mem_rdata;
                        end
                        state <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (state == S_ACCESS);
    assign mem_we    = mem_en && we_q;
    assign if_valid  = (state == S_DONE) && !owner_dm;
    assign dm_valid  = (state == S_DONE) && owner_dm;
    assign busy      = (state != S_IDLE);
    assign stall_if  = rst_n && if_req && !if_valid;
    assign stall_mem = rst_n && dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        if_req;
    logic [8:0]  if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [8:0]  dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] mem_rdata;

    logic        if_valid, dm_valid, mem_en, mem_we, stall_if, stall_mem, busy;
    logic [15:0] if_rdata, dm_rdata, mem_wdata;
    logic [8:0]  mem_addr;

    logic        d3_if_valid, d3_dm_valid, d3_mem_en, d3_mem_we, d3_stall_if, d3_stall_mem, d3_busy;
    logic [15:0] d3_if_rdata, d3_dm_rdata, d3_mem_wdata;
    logic [8:0]  d3_mem_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(9), .MEM_LAT(1), .STARVE_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(9), .MEM_LAT(3), .STARVE_MAX(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_valid(d3_if_valid), .if_rdata(d3_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(d3_dm_valid), .dm_rdata(d3_dm_rdata),
        .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(d3_stall_if), .stall_mem(d3_stall_mem), .busy(d3_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) adv();
    endtask

    logic saw_valid;

    initial begin
        rst_n = 1'b0; halt = 1'b0; if_req = 1'b1; if_addr = '0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_stall_if", stall_if, 0);
        chk("rst_stall_mem", stall_mem, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        if_req = 1'b0; dm_req = 1'b0;
        adv(); rst_n = 1'b1;
        idle(3);

        // Tests 1 and 2: single fetch on MEM_LAT=1 (dut) and MEM_LAT=3 (dut3).
        adv(); if_req = 1'b1; if_addr = 9'h010; mem_rdata = 16'hA5C3; settle();
        chk("t1_c0_stall_if", stall_if, 1);
        chk("t1_c0_mem_en", mem_en, 0);
        chk("t2_c0_busy", d3_busy, 0);
        adv(); settle();
        chk("t1_c1_mem_en", mem_en, 1);
        chk("t1_c1_mem_we", mem_we, 0);
        chk("t1_c1_mem_addr", mem_addr, 9'h010);
        chk("t1_c1_stall_if", stall_if, 1);
        chk("t2_c1_busy", d3_busy, 1);
        chk("t2_c1_mem_en", d3_mem_en, 1);
        adv(); settle();
        chk("t1_c2_mem_en", mem_en, 0);
        chk("t1_c2_if_valid", if_valid, 0);
        chk("t1_c2_stall_if", stall_if, 1);
        adv(); settle();
        chk("t1_c3_if_valid", if_valid, 1);
        chk("t1_c3_if_rdata", if_rdata, 16'hA5C3);
        chk("t1_c3_stall_if", stall_if, 0);
        chk("t2_c3_if_valid", d3_if_valid, 0);
        adv(); settle();
        chk("t1_c4_if_valid", if_valid, 0);
        chk("t2_c4_if_valid", d3_if_valid, 0);
        chk("t2_c4_busy", d3_busy, 1);
        adv(); settle();
        chk("t2_c5_if_valid", d3_if_valid, 1);
        chk("t2_c5_if_rdata", d3_if_rdata, 16'hA5C3);
        chk("t2_c5_busy", d3_busy, 1);
        adv(); if_req = 1'b0; settle();
        chk("t2_c6_if_valid", d3_if_valid, 0);
        chk("t2_c6_busy", d3_busy, 0);
        idle(8);

        // Test 3: simultaneous requests, data wins first.
        adv(); if_req = 1'b1; if_addr = 9'h020; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h100;
        mem_rdata = 16'h5A5A; settle();
        chk("t3_c0_stall_mem", stall_mem, 1);
        adv(); settle();
        chk("t3_c1_mem_en", mem_en, 1);
        chk("t3_c1_mem_addr", mem_addr, 9'h100);
        chk("t3_c1_mem_we", mem_we, 0);
        adv(); settle();
        adv(); settle();
        chk("t3_c3_dm_valid", dm_valid, 1);
        chk("t3_c3_dm_rdata", dm_rdata, 16'h5A5A);
        chk("t3_c3_if_valid", if_valid, 0);
        chk("t3_c3_stall_mem", stall_mem, 0);
        chk("t3_c3_stall_if", stall_if, 1);
        adv(); dm_req = 1'b0; mem_rdata = 16'h1357; settle();
        chk("t3_c4_mem_en", mem_en, 0);
        adv(); settle();
        chk("t3_c5_mem_en", mem_en, 1);
        chk("t3_c5_mem_addr", mem_addr, 9'h020);
        adv(); settle();
        adv(); settle();
        chk("t3_c7_if_valid", if_valid, 1);
        chk("t3_c7_if_rdata", if_rdata, 16'h1357);
        chk("t3_c7_dm_valid", dm_valid, 0);
        adv(); if_req = 1'b0; settle();
        idle(10);

        // Test 4: anti-starvation, grant order DM,DM,DM,IF,DM.
        adv(); if_req = 1'b1; if_addr = 9'h020; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h100;
        mem_rdata = 16'h1357; settle();
        chk("t4_c0_starve", dut.starve_cnt, 0);
        for (int c = 1; c <= 17; c++) begin
            adv(); settle();
            chk($sformatf("t4_c%0d_mem_en", c), mem_en, (c % 4 == 1) ? 1 : 0);
            if (c % 4 == 1) begin
                chk($sformatf("t4_c%0d_mem_addr", c), mem_addr, (c == 13) ? 9'h020 : 9'h100);
                chk($sformatf("t4_c%0d_starve", c), dut.starve_cnt,
                    (c == 13) ? 0 : (c == 17) ? 1 : (c + 3) / 4);
            end
        end
        adv(); if_req = 1'b0; dm_req = 1'b0; settle();
        idle(10);

        // Test 5: store.
        adv(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h1F0; dm_wdata = 16'h1234;
        mem_rdata = 16'hFFFF; settle();
        adv(); settle();
        chk("t5_c1_mem_en", mem_en, 1);
        chk("t5_c1_mem_we", mem_we, 1);
        chk("t5_c1_mem_addr", mem_addr, 9'h1F0);
        chk("t5_c1_mem_wdata", mem_wdata, 16'h1234);
        adv(); settle();
        chk("t5_c2_mem_en", mem_en, 0);
        chk("t5_c2_mem_we", mem_we, 0);
        adv(); settle();
        chk("t5_c3_dm_valid", dm_valid, 1);
        chk("t5_c3_dm_rdata", dm_rdata, 16'h1357);
        adv(); dm_req = 1'b0; dm_we = 1'b0; settle();
        chk("t5_c4_dm_valid", dm_valid, 0);
        idle(10);

        // Test 6: halt during fetch ACCESS, then reset during a later WAIT.
        adv(); if_req = 1'b1; if_addr = 9'h030; mem_rdata = 16'h0BEE; settle();
        adv(); halt = 1'b1; settle();
        chk("t6_c1_mem_en", mem_en, 1);
        adv(); settle();
        adv(); settle();
        chk("t6_c3_if_valid", if_valid, 1);
        chk("t6_c3_if_rdata", if_rdata, 16'h0BEE);
        for (int c = 4; c <= 7; c++) begin
            adv(); settle();
            chk($sformatf("t6_c%0d_busy", c), busy, 0);
            chk($sformatf("t6_c%0d_stall_if", c), stall_if, 1);
        end
        adv(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h0AA; settle();
        adv(); settle();
        chk("t6_c9_mem_en", mem_en, 1);
        adv(); settle();
        chk("t6_c10_busy", busy, 1);
        rst_n = 1'b0; #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_mem_en", mem_en, 0);
        chk("t6_rst_mem_addr", mem_addr, 0);
        chk("t6_rst_if_rdata", if_rdata, 0);
        chk("t6_rst_stall_if", stall_if, 0);
        chk("t6_rst_stall_mem", stall_mem, 0);
        if_req = 1'b0; dm_req = 1'b0; halt = 1'b0;
        adv(); rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            adv(); settle();
            if (if_valid || dm_valid || mem_en) saw_valid = 1'b1;
        end
        chk("t6_no_valid_after_reset", saw_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
